rx_frame_buffer: RTL and testbench

// - Receive-side buffer directly downstream of serialToParallelWrapper.
// - Captures each deserialized frame on the wrapper's complete pulse into a DEPTH-entry FIFO.
// - Presents frames to the consumer with a valid/ready handshake.
// - Flags frames lost to a full buffer with a sticky overflow bit.

---
 rtl/rx_frame_buffer.sv | 88 ++++++++
 tb/tb_rx_frame_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_buffer.sv
// Receive-side frame FIFO: captures deserialized frames on complete edges.
// Optional RXBUF_FRAME_MASK_EN zeroes bits at and above framesize.
module rx_frame_buffer #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              complete,
  input  logic [WIDTH-1:0]  parallel,
  input  logic [WIDTH-1:0]  framesize,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              complete_d;
  logic              cap;
  logic              pop;
  logic              wr;
  logic              drop;
  logic [WIDTH-1:0]  word;

`ifdef RXBUF_FRAME_MASK_EN
  always_comb begin
    word = parallel;
    if (framesize != '0 && framesize < WIDTH'(WIDTH))
      word = parallel & ~({WIDTH{1'b1}} << framesize);
  end
`else
  logic unused_framesize;
  assign unused_framesize = ^framesize;
  assign word = parallel;
`endif

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign data_valid = ~empty;
  assign data_out   = empty ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a frame when the head leaves in the same cycle
  assign cap  = complete & ~complete_d & Enable;
  assign pop  = data_valid & data_ready;
  assign wr   = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      complete_d <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      complete_d <= complete;
      if (wr)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr && !pop)
        count <= count + (ADDR_W+1)'(1);
      else if (pop && !wr)
        count <= count - (ADDR_W+1)'(1);
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr)
      mem[wr_ptr] <= word;
  end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Self-checking bench for rx_frame_buffer: vector table, corner
// sequences and randomized traffic against a queue model.
module tb_rx_frame_buffer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        complete = 1'b0;
  logic [63:0] parallel = '0;
  logic [63:0] framesize = '0;
  logic [63:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q[$];
  logic        m_cd = 1'b0;
  logic        m_ov = 1'b0;

  rx_frame_buffer #(.WIDTH(64), .DEPTH(4), .ADDR_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .complete(complete), .parallel(parallel),
    .framesize(framesize), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        c;
    logic        e;
    logic        r;
    logic        clr;
    logic [63:0] p;
    logic [63:0] fs;
    logic [2:0]  ecnt;
    logic        evalid;
    logic [63:0] eout;
    logic        eov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] stored(input logic [63:0] p,
                                         input logic [63:0] fs);
`ifdef RXBUF_FRAME_MASK_EN
    if (fs == 0 || fs >= 64)
      return p;
    return p & ((64'd1 << fs) - 64'd1);
`else
    return p;
`endif
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".valid"}, 64'(data_valid), 64'(q.size() != 0));
    chk({tag, ".out"}, data_out, (q.size() != 0) ? q[0] : 64'd0);
    chk({tag, ".full"}, 64'(full), 64'(q.size() == 4));
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ov));
  endtask

  // One clock: drive, let the edge happen, update model, compare
  task automatic cycle(input logic c, input logic e, input logic r,
                       input logic clr, input logic [63:0] p,
                       input logic [63:0] fs, input string tag);
    bit cap, pop, isfull;
    complete = c; Enable = e; data_ready = r;
    clear_overflow = clr; parallel = p; framesize = fs;
    @(posedge Clock);
    cap    = c && !m_cd && e;
    pop    = (q.size() != 0) && r;
    isfull = (q.size() == 4);
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (!isfull || pop) q.push_back(stored(p, fs));
      else m_ov = 1'b1;
    end
    if (!(cap && isfull && !pop) && clr) m_ov = 1'b0;
    m_cd = c;
    #1;
    model_check(tag);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    complete = 0; Enable = 0; data_ready = 0; clear_overflow = 0;
    q.delete(); m_cd = 0; m_ov = 0;
    #12;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
  endtask

  task automatic add(input logic c, input logic e, input logic r,
                     input logic clr, input logic [63:0] p,
                     input logic [63:0] fs, input logic [2:0] ecnt,
                     input logic ev, input logic [63:0] eo,
                     input logic eov);
    vec_t v;
    v.c = c; v.e = e; v.r = r; v.clr = clr; v.p = p; v.fs = fs;
    v.ecnt = ecnt; v.evalid = ev; v.eout = eo; v.eov = eov;
    vecs.push_back(v);
  endtask

  localparam logic [63:0] F0 = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] X1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] X2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] X3 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] X4 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] mexp;
    logic [63:0] fr[4];
`ifdef RXBUF_FRAME_MASK_EN
    mexp = 64'h0000_0000_0000_00FF;
`else
    mexp = ONES;
`endif
    add(1,1,0,0,F0,0, 3'd1,1,F0,0);
    add(1,1,0,0,F0,0, 3'd1,1,F0,0);
    add(1,1,0,0,F0,0, 3'd1,1,F0,0);
    add(0,1,0,0,0, 0, 3'd1,1,F0,0);
    add(1,1,0,0,X1,0, 3'd2,1,F0,0);
    add(0,1,0,0,0, 0, 3'd2,1,F0,0);
    add(1,1,0,0,X2,0, 3'd3,1,F0,0);
    add(0,1,0,0,0, 0, 3'd3,1,F0,0);
    add(1,1,0,0,X3,0, 3'd4,1,F0,0);
    add(0,1,0,0,0, 0, 3'd4,1,F0,0);
    add(1,1,0,0,X4,0, 3'd4,1,F0,1);
    add(0,1,0,1,0, 0, 3'd4,1,F0,0);
    add(0,1,1,0,0, 0, 3'd3,1,X1,0);
    add(0,1,1,0,0, 0, 3'd2,1,X2,0);
    add(0,1,1,0,0, 0, 3'd1,1,X3,0);
    add(0,1,1,0,0, 0, 3'd0,0,0, 0);
    add(0,1,1,0,0, 0, 3'd0,0,0, 0);
    add(1,1,0,0,ONES,64'd8, 3'd1,1,mexp,0);
    add(0,1,1,0,0, 0, 3'd0,0,0, 0);

    do_reset();
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.valid", 64'(data_valid), 64'd0);
    chk("rst.out", data_out, 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);

    foreach (vecs[i]) begin
      cycle(vecs[i].c, vecs[i].e, vecs[i].r, vecs[i].clr,
            vecs[i].p, vecs[i].fs, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.count", i), 64'(count), 64'(vecs[i].ecnt));
      chk($sformatf("tbl%0d.valid", i), 64'(data_valid),
          64'(vecs[i].evalid));
      chk($sformatf("tbl%0d.out", i), data_out, vecs[i].eout);
      chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(vecs[i].eov));
    end

    // Full FIFO: capture and pop together
    for (int i = 0; i < 4; i++) begin
      fr[i] = {$urandom, $urandom};
      cycle(1,1,0,0,fr[i],0,"fill");
      cycle(0,1,0,0,0,0,"fill");
    end
    chk("fp.count0", 64'(count), 64'd4);
    cycle(1,1,1,0,X4,0,"fp");
    chk("fp.count", 64'(count), 64'd4);
    chk("fp.ovf", 64'(overflow), 64'd0);
    chk("fp.head", data_out, fr[1]);
    for (int i = 0; i < 3; i++) cycle(0,1,1,0,0,0,"fpdrain");
    chk("fp.tail", data_out, X4);
    cycle(0,1,1,0,0,0,"fpdrain");
    chk("fp.empty", 64'(empty), 64'd1);

    // Edge seen while disabled is lost for good
    cycle(1,0,0,0,X1,0,"en0");
    chk("en0.count", 64'(count), 64'd0);
    cycle(1,1,0,0,X1,0,"en1");
    chk("en1.count", 64'(count), 64'd0);
    cycle(0,1,0,0,0,0,"en2");
    cycle(1,1,0,0,X2,0,"en3");
    chk("en3.count", 64'(count), 64'd1);
    chk("en3.out", data_out, X2);

    // Overflow set beats clear in the same cycle
    cycle(0,1,0,0,0,0,"ov");
    for (int i = 0; i < 3; i++) begin
      cycle(1,1,0,0,X3,0,"ov");
      cycle(0,1,0,0,0,0,"ov");
    end
    cycle(1,1,0,1,X1,0,"ovset");
    chk("ovset.ovf", 64'(overflow), 64'd1);
    cycle(0,1,0,1,0,0,"ovclr");
    chk("ovclr.ovf", 64'(overflow), 64'd0);

    // Asynchronous reset with three entries held
    cycle(0,1,1,0,0,0,"pre");
    chk("pre.count", 64'(count), 64'd3);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.valid", 64'(data_valid), 64'd0);
    chk("arst.out", data_out, 64'd0);
    q.delete(); m_cd = 0; m_ov = 0;
    complete = 0; data_ready = 0; clear_overflow = 0;
    @(negedge Clock);
    Reset = 1'b1;

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0),
            {$urandom, $urandom},
            64'($urandom_range(0, 70)),
            "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
